// File: rtl/ysyx_seq.sv
// Multi-cycle control sequencer: fetch/decode/exec/mem/wb with bus timeout.
// Optional perf counters are enabled by defining YSYX_SEQ_PERF_EN.
module ysyx_seq #(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ifu_req_valid,
    input  logic        ifu_req_ready,
    input  logic        ifu_resp_valid,
    input  logic        dec_is_load,
    input  logic        dec_is_store,
    input  logic        dec_is_ebreak,
    input  logic        dec_illegal,
    output logic        lsu_req_valid,
    input  logic        lsu_req_ready,
    input  logic        lsu_resp_valid,
    output logic        inst_we,
    output logic        pc_we,
    output logic        rf_we,
    output logic [2:0]  state,
    output logic        halt,
    output logic        err,
    output logic [63:0] perf_cycle,
    output logic [63:0] perf_instret
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_FWAIT  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_MWAIT  = 3'd5,
        S_WB     = 3'd6,
        S_HALT   = 3'd7
    } state_e;

    localparam logic [7:0] TMO_LAST = 8'(BUS_TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [7:0] wcnt_q, wcnt_d;
    logic       err_q, err_d;
    logic       tmo;

    assign tmo = (wcnt_q == TMO_LAST);

    // A handshake or response in the same cycle as the timeout wins.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        err_d   = err_q;
        unique case (state_q)
            S_FETCH: begin
                if (ifu_req_ready) begin
                    state_d = S_FWAIT;
                    wcnt_d  = '0;
                end else if (tmo) begin
                    state_d = S_HALT;
                    err_d   = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + 8'd1;
                end
            end
            S_FWAIT: begin
                if (ifu_resp_valid) begin
                    state_d = S_DECODE;
                end else if (tmo) begin
                    state_d = S_HALT;
                    err_d   = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + 8'd1;
                end
            end
            S_DECODE: begin
                if (dec_illegal) begin
                    state_d = S_HALT;
                    err_d   = 1'b1;
                end else if (dec_is_ebreak) begin
                    state_d = S_HALT;
                    err_d   = 1'b0;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (dec_is_load || dec_is_store) begin
                    state_d = S_MEM;
                    wcnt_d  = '0;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (lsu_req_ready) begin
                    state_d = S_MWAIT;
                    wcnt_d  = '0;
                end else if (tmo) begin
                    state_d = S_HALT;
                    err_d   = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + 8'd1;
                end
            end
            S_MWAIT: begin
                if (lsu_resp_valid) begin
                    state_d = S_WB;
                end else if (tmo) begin
                    state_d = S_HALT;
                    err_d   = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + 8'd1;
                end
            end
            S_WB: begin
                state_d = S_FETCH;
                wcnt_d  = '0;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            wcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
        end
    end

    // Write enables are suppressed while reset abandons a transaction.
    assign ifu_req_valid = (state_q == S_FETCH);
    assign lsu_req_valid = (state_q == S_MEM);
    assign inst_we       = (state_q == S_FWAIT) && ifu_resp_valid && !rst;
    assign pc_we         = (state_q == S_WB) && !rst;
    assign rf_we         = pc_we && !dec_is_store;
    assign state         = state_q;
    assign halt          = (state_q == S_HALT);
    assign err           = err_q;

`ifdef YSYX_SEQ_PERF_EN
    logic [63:0] cyc_q, ret_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q <= '0;
            ret_q <= '0;
        end else begin
            if (state_q != S_HALT) cyc_q <= cyc_q + 64'd1;
            if (state_q == S_WB)   ret_q <= ret_q + 64'd1;
        end
    end

    assign perf_cycle   = cyc_q;
    assign perf_instret = ret_q;
`else
    assign perf_cycle   = '0;
    assign perf_instret = '0;
`endif

endmodule

// File: doc/ysyx_seq.md
YSYX_SEQ -- requirements
Module: ysyx_seq

Interface
REQ-001 SHALL have parameter BUS_TIMEOUT, default 255: max wait cycles for any memory response, 1..255.
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports ifu_req_valid output 1 fetch request; ifu_req_ready input 1 fetch accept; ifu_resp_valid input 1 instruction word valid.
REQ-005 SHALL have ports dec_is_load, dec_is_store, dec_is_ebreak, dec_illegal  input  1 each  IDU decode flags, stable from DECODE onward.
REQ-006 SHALL have ports lsu_req_valid output 1; lsu_req_ready input 1; lsu_resp_valid input 1  data-memory handshake.
REQ-007 SHALL have outputs inst_we 1 (latch instruction register), pc_we 1 (PC update), rf_we 1 (register-file write).
REQ-008 SHALL have outputs state 3 (current state code), halt 1, err 1.
REQ-009 SHALL have outputs perf_cycle 64 and perf_instret 64 (see Configuration).

Function
REQ-010 SHALL implement states FETCH=0, FWAIT=1, DECODE=2, EXEC=3, MEM=4, MWAIT=5, WB=6, HALT=7, with state output equal to the code.
REQ-011 SHALL drive ifu_req_valid=1 only in FETCH, held until ifu_req_valid&&ifu_req_ready, then go to FWAIT.
REQ-012 SHALL ignore ifu_resp_valid outside FWAIT; in FWAIT, on ifu_resp_valid, pulse inst_we for that cycle and go to DECODE.
REQ-013 SHALL in DECODE go to HALT with err=0 if dec_is_ebreak, to HALT with err=1 if dec_illegal (illegal priority over ebreak), else to EXEC.
REQ-014 SHALL in EXEC go to MEM if dec_is_load or dec_is_store, else to WB.
REQ-015 SHALL drive lsu_req_valid=1 only in MEM, held until handshake, then go to MWAIT; in MWAIT, on lsu_resp_valid, go to WB.
REQ-016 SHALL in WB assert pc_we=1 and rf_we=!dec_is_store for exactly one cycle, then go to FETCH.
REQ-017 SHALL produce, with zero-wait memory, 5 cycles per ALU instruction and 7 per load/store.
REQ-018 SHALL keep an 8-bit wait counter, cleared on entering FETCH/FWAIT/MEM/MWAIT, incremented each cycle stalled there; on reaching BUS_TIMEOUT, go to HALT with err=1.
REQ-019 SHALL give a valid handshake/response priority over timeout when both occur in the same cycle.
REQ-020 SHALL hold HALT until rst: halt=1, err held, all request/enable outputs 0.
REQ-021 SHALL drive all enables/requests as functions of registered state only (inst_we also qualified by ifu_resp_valid); no combinational path from ready to valid.

Reset
REQ-022 SHALL on rst enter FETCH, clear wait counter, halt=0, err=0, perf counters 0; rst asserted mid-transaction abandons it with no pc_we/rf_we pulse in that cycle.
REQ-023 SHALL assert ifu_req_valid in the first cycle after rst deasserts.

Configuration
REQ-024 SHALL, with YSYX_SEQ_PERF_EN defined, increment perf_cycle every non-HALT cycle and perf_instret on each WB cycle, both wrapping modulo 2^64.
REQ-025 SHALL, without YSYX_SEQ_PERF_EN, drive perf_cycle and perf_instret constant 0 with no counter registers.

Verification
REQ-026 ALU inst, ready=1, resp one cycle after accept -> states 0,1,2,3,6,0; one pc_we and rf_we pulse; perf_instret=1 after WB.
REQ-027 Store, lsu_req_ready low 3 cycles -> MEM held 4 cycles with lsu_req_valid=1; WB with rf_we=0, pc_we=1.
REQ-028 BUS_TIMEOUT=4, no ifu_resp_valid -> HALT after 4 FWAIT stall cycles, err=1, halt=1 until rst.
REQ-029 ifu_resp_valid in same cycle counter hits BUS_TIMEOUT -> DECODE, err=0.
REQ-030 dec_is_ebreak=1 and dec_illegal=1 together -> HALT with err=1; ebreak alone -> err=0.
REQ-031 rst pulsed in MWAIT -> next cycle state=0, no rf_we, perf counters 0 (PERF_EN build).
